decoder_3to8: RTL and testbench



---
 rtl/decoder_3to8_pkg.sv | 12 +
 rtl/decoder_3to8_onehot_decode.sv | 28 ++
 rtl/decoder_3to8.sv | 59 +++++
 tb/tb_decoder_3to8.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/decoder_3to8_pkg.sv
// Shared constants and the reference one-hot decode used by select decoders.
package decoder_3to8_pkg;

    localparam int DEC_IN_W  = 3;
    localparam int DEC_OUT_W = 8;

    // An unknown select propagates as all-X through the shift in simulation.
    function automatic logic [DEC_OUT_W-1:0] decode_onehot(input logic [DEC_IN_W-1:0] sel);
        return DEC_OUT_W'(1) << sel;
    endfunction

endpackage

// File: rtl/decoder_3to8_onehot_decode.sv
// Combinational binary-to-one-hot core with optional one-cold inversion.
module onehot_decode #(
    parameter int IN_W       = 3,
    parameter int OUT_W      = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [IN_W-1:0]  sel_i,
    output logic [OUT_W-1:0] y_o
);

    generate
        if (OUT_W != 2**IN_W) begin : g_bad_width
            $error("onehot_decode: OUT_W must equal 2**IN_W");
        end
    endgenerate

    logic [OUT_W-1:0] onehot;

    // Per-line equality keeps X/Z on the select visible as X on every line.
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_line
            assign onehot[gi] = (sel_i == IN_W'(gi));
        end
    endgenerate

    assign y_o = ACTIVE_LOW ? ~onehot : onehot;

endmodule

// File: rtl/decoder_3to8.sv
// 3-to-8 decoder: combinational output plus an enabled register stage with valid flag.
module decoder_3to8
    import decoder_3to8_pkg::*;
#(
    parameter int IN_W       = DEC_IN_W,
    parameter int OUT_W      = DEC_OUT_W,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  X,
    output logic [OUT_W-1:0] Y,
    output logic [OUT_W-1:0] Y_q,
    output logic             Y_q_valid
);

    localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    logic [OUT_W-1:0] dec_y;
    logic [OUT_W-1:0] y_reg_q;
    logic [OUT_W-1:0] y_reg_d;
    logic             valid_q;
    logic             valid_d;

    onehot_decode #(
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_core (
        .sel_i (X),
        .y_o   (dec_y)
    );

    always_comb begin
        y_reg_d = y_reg_q;
        valid_d = valid_q;
        if (en) begin
            y_reg_d = dec_y;
            valid_d = 1'b1;
        end
    end

    // Reset wins over enable; Y itself is never gated by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg_q <= INACTIVE;
            valid_q <= 1'b0;
        end else begin
            y_reg_q <= y_reg_d;
            valid_q <= valid_d;
        end
    end

    assign Y         = dec_y;
    assign Y_q       = y_reg_q;
    assign Y_q_valid = valid_q;

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8 (one-hot and one-cold builds side by side).
module tb_decoder_3to8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [2:0] X   = 3'd0;

    logic [7:0] y_hi, yq_hi, y_lo, yq_lo;
    logic       v_hi, v_lo;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state for the registered path.
    logic [7:0] exp_q_hi = 8'h00;
    logic [7:0] exp_q_lo = 8'hFF;
    logic       exp_v    = 1'b0;

    always #5 clk = ~clk;

    decoder_3to8 #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .X(X),
        .Y(y_hi), .Y_q(yq_hi), .Y_q_valid(v_hi)
    );

    decoder_3to8 #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .X(X),
        .Y(y_lo), .Y_q(yq_lo), .Y_q_valid(v_lo)
    );

    function automatic logic [7:0] ref_dec(input int k);
        int p = 1;
        repeat (k) p = p * 2;
        return p[7:0];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
        $display("check %-10s X=%0d rst=%0b en=%0b observed=%h expected=%h",
                 tag, X, rst, en, obs, expv);
    endtask

    // Update the model with the inputs seen at the coming edge, then cross it.
    task automatic tick();
        if (rst) begin
            exp_q_hi = 8'h00;
            exp_q_lo = 8'hFF;
            exp_v    = 1'b0;
        end else if (en) begin
            exp_q_hi = ref_dec(int'(X));
            exp_q_lo = ~ref_dec(int'(X));
            exp_v    = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag);
        check({tag, "_q"},  yq_hi, exp_q_hi);
        check({tag, "_ql"}, yq_lo, exp_q_lo);
        check({tag, "_v"},  {7'd0, v_hi}, {7'd0, exp_v});
        check({tag, "_vl"}, {7'd0, v_lo}, {7'd0, exp_v});
    endtask

    task automatic check_comb(input string tag);
        #5;
        check(tag, y_hi, ref_dec(int'(X)));
        check({tag, "_l"}, y_lo, ~ref_dec(int'(X)));
    endtask

    initial begin
        int pipe_x [4] = '{0, 7, 1, 6};
        logic [7:0] pipe_exp [4] = '{8'h01, 8'h80, 8'h02, 8'h40};

        // Reset held with en=1, X=5 for two edges.
        rst = 1'b1; en = 1'b1; X = 3'd5;
        tick(); tick();
        check("rst_q",  yq_hi, 8'h00);
        check("rst_ql", yq_lo, 8'hFF);
        check("rst_v",  {7'd0, v_hi}, 8'h00);
        check("rst_y",  y_hi, 8'h20);
        check_reg("rst");

        // Exhaustive combinational sweep, still in reset.
        for (int k = 0; k < 8; k++) begin
            X = 3'(k);
            check_comb("sweep");
        end

        // Random combinational, stopping at the first miscompare.
        for (int i = 0; i < 50; i++) begin
            int e0;
            e0 = n_err;
            X = 3'($urandom_range(0, 7));
            check_comb("rand_y");
            if (n_err != e0) break;
        end

        // Release reset: first enabled edge loads and raises valid.
        X = 3'd5; en = 1'b1; rst = 1'b0;
        tick();
        check("rel_q", yq_hi, 8'h20);
        check("rel_v", {7'd0, v_hi}, 8'h01);
        check_reg("rel");

        // Enable hold.
        X = 3'd3; en = 1'b1;
        tick();
        check("ld3_q", yq_hi, 8'h08);
        en = 1'b0; X = 3'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_q", yq_hi, 8'h08);
            check("hold_y", y_hi, 8'h40);
            check_reg("hold");
        end

        // Back-to-back pipeline.
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            X = 3'(pipe_x[i]);
            tick();
            check("pipe_q", yq_hi, pipe_exp[i]);
            check_reg("pipe");
        end

        // Random registered traffic with occasional mid-run reset.
        for (int i = 0; i < 40; i++) begin
            X   = 3'($urandom_range(0, 7));
            en  = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 9) == 0);
            check_comb("rnd_y");
            tick();
            check_reg("rnd");
        end

        // Reset mid-operation with en=1 still clears the stage.
        rst = 1'b1; en = 1'b1; X = 3'd4;
        tick();
        check_reg("mrst");
        rst = 1'b0;

        // One-cold build spot check.
        X = 3'd2;
        #5;
        check("al_y", y_lo, 8'hFB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
